fractal_sync_leaf: RTL



---
 rtl/fractal_sync_leaf.sv | 107 ++++++++++
 1 files changed

// File: rtl/fractal_sync_leaf.sv
// Leaf requester for the fractal synchronization tree: one barrier at a time,
// full sync/wake/ack handshake toward a tree node, response with error and wait latency.
module fractal_sync_leaf #(
    parameter int unsigned LVL_WIDTH = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [LVL_WIDTH-1:0] req_level_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic [CNT_WIDTH-1:0] rsp_cycles_o,
    output logic                 sync_o,
    output logic [LVL_WIDTH-1:0] level_o,
    output logic                 ack_o,
    input  logic                 wake_i,
    input  logic                 error_i
);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StWait,
        StAck,
        StDrain,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [LVL_WIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 err_q, err_d;

    // Saturating increment: holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            level_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        sync_o       = 1'b0;
        ack_o        = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_error_o  = 1'b0;
        rsp_cycles_o = '0;
        case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    level_d = req_level_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StSync;
                end
            end
            StSync: begin
                sync_o  = 1'b1;
                cnt_d   = cnt_inc;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (wake_i) begin
                    err_d   = error_i;
                    state_d = StAck;
                end
            end
            StAck: begin
                ack_o   = 1'b1;
                state_d = StDrain;
            end
            StDrain: begin
                // Wait for the node to drop wake so a new sync cannot merge into this barrier.
                if (!wake_i) state_d = StResp;
            end
            StResp: begin
                rsp_valid_o  = 1'b1;
                rsp_error_o  = err_q;
                rsp_cycles_o = cnt_q;
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign level_o = level_q;

endmodule
